// File: rtl/vicmidi_pkg.sv
// Shared constants for the VIC-MIDI UART: register map, STATUS/CTRL bit
// positions and the TX/RX state encodings.
package vicmidi_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_CTRL   = 3'd2;
   localparam logic [2:0] ADDR_COUNT  = 3'd3;

   localparam int unsigned ST_RX_AVAIL = 0;
   localparam int unsigned ST_TX_READY = 1;
   localparam int unsigned ST_OVERRUN  = 2;
   localparam int unsigned ST_FRAMING  = 3;
   localparam int unsigned ST_IRQ      = 7;

   localparam int unsigned CT_PORT_SEL = 0;
   localparam int unsigned CT_RX_IE    = 1;
   localparam int unsigned CT_TX_IE    = 2;
   localparam int unsigned CT_THRU     = 3;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/vicmidi_uart_if.sv
// Cartridge I/O register bus between the host decode and the UART.
interface vicmidi_uart_if;
   logic       cs;
   logic       r_w;
   logic [2:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       irq;

   modport master (output cs, r_w, address, data_in, input data_out, irq);
   modport slave  (input cs, r_w, address, data_in, output data_out, irq);
endinterface

// File: rtl/vicmidi_fifo.sv
// Synchronous RX FIFO; a pop frees a slot for a push in the same cycle even when full.
module vicmidi_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   assign full  = (occ == OCC_W'(DEPTH));
   assign empty = (occ == '0);
   assign count = occ;
   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/vicmidi_uart.sv
// VIC-MIDI UART: register-mapped 8N1 transmitter, FIFO-buffered receiver,
// MIDI/RS-232 port routing with optional MIDI THRU and an interrupt request.
module vicmidi_uart
   import vicmidi_pkg::*;
#(
   parameter int unsigned DIV_MIDI   = 32,
   parameter int unsigned DIV_RS232  = 106,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic          clock,
   input  logic          reset,
   vicmidi_uart_if.slave bus,
   input  logic          midi_rxd,
   input  logic          rs232_rxd,
   output logic          midi_txd,
   output logic          rs232_txd
);

   localparam int unsigned MAX_DIV = (DIV_RS232 > DIV_MIDI) ? DIV_RS232 : DIV_MIDI;
   localparam int unsigned CNT_W   = $clog2(MAX_DIV) + 1;
   localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]       ctrl;
   logic             overrun, framing_err;
   logic [1:0]       midi_sync, rs_sync;
   logic             rx_in, rx_prev;

   logic [1:0]       tx_state, tx_state_n;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
   logic [2:0]       tx_bits, tx_bits_n;
   logic [7:0]       tx_shift, tx_shift_n, hold_data;
   logic             hold_full, tx_load, tx_last, tx_line;

   logic [1:0]       rx_state, rx_state_n;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]       rx_bits, rx_bits_n;
   logic [7:0]       rx_shift, rx_shift_n;
   logic             rx_push, set_fe, set_ov, rx_last, rx_half;

   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_rdata;
   logic [OCC_W-1:0] fifo_count;

   logic             wr_data, wr_status, wr_ctrl, rd_data, pop, port_chg;
   logic             port_sel, thru, tx_ready, rx_avail, irq_int;
   logic [CNT_W-1:0] act_div;
   logic [7:0]       rdata;

   assign wr_data   = bus.cs && !bus.r_w && (bus.address == ADDR_DATA);
   assign wr_status = bus.cs && !bus.r_w && (bus.address == ADDR_STATUS);
   assign wr_ctrl   = bus.cs && !bus.r_w && (bus.address == ADDR_CTRL);
   assign rd_data   = bus.cs &&  bus.r_w && (bus.address == ADDR_DATA);
   assign pop       = rd_data && !fifo_empty;

   assign port_sel  = ctrl[CT_PORT_SEL];
   assign thru      = ctrl[CT_THRU];
   assign port_chg  = wr_ctrl && (bus.data_in[CT_PORT_SEL] != port_sel);
   assign act_div   = port_sel ? CNT_W'(DIV_RS232) : CNT_W'(DIV_MIDI);
   assign tx_ready  = !hold_full;
   assign rx_avail  = !fifo_empty;

   // Both inputs are synchronised so THRU works whichever port is selected
   always_ff @(posedge clock) begin
      if (reset) begin
         midi_sync <= 2'b11;
         rs_sync   <= 2'b11;
         rx_prev   <= 1'b1;
      end else begin
         midi_sync <= {midi_sync[0], midi_rxd};
         rs_sync   <= {rs_sync[0], rs232_rxd};
         rx_prev   <= rx_in;
      end
   end

   assign rx_in = port_sel ? rs_sync[1] : midi_sync[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl        <= '0;
         overrun     <= 1'b0;
         framing_err <= 1'b0;
         hold_full   <= 1'b0;
         hold_data   <= '0;
      end else begin
         if (wr_ctrl) ctrl <= bus.data_in[3:0];
         if (set_ov) overrun <= 1'b1;
         else if (wr_status && bus.data_in[ST_OVERRUN]) overrun <= 1'b0;
         if (set_fe) framing_err <= 1'b1;
         else if (wr_status && bus.data_in[ST_FRAMING]) framing_err <= 1'b0;
         if (tx_load) begin
            hold_full <= 1'b0;
         end else if (wr_data && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= bus.data_in;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_bits  <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_div   <= tx_div_n;
         tx_bits  <= tx_bits_n;
         tx_shift <= tx_shift_n;
      end
   end

   assign tx_last = (tx_cnt == tx_div - CNT_W'(1));

   // TX: divisor is latched per frame; a full holding register chains straight from STOP
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_div_n   = tx_div;
      tx_bits_n  = tx_bits;
      tx_shift_n = tx_shift;
      tx_load    = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (hold_full) begin
               tx_load    = 1'b1;
               tx_shift_n = hold_data;
               tx_div_n   = act_div;
               tx_cnt_n   = '0;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (tx_last) begin
               tx_cnt_n   = '0;
               tx_bits_n  = '0;
               tx_state_n = TX_DATA;
            end else tx_cnt_n = tx_cnt + CNT_W'(1);
         end
         TX_DATA: begin
            if (tx_last) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b0, tx_shift[7:1]};
               tx_bits_n  = tx_bits + 3'd1;
               if (tx_bits == 3'd7) tx_state_n = TX_STOP;
            end else tx_cnt_n = tx_cnt + CNT_W'(1);
         end
         default: begin
            if (tx_last) begin
               tx_cnt_n = '0;
               if (hold_full) begin
                  tx_load    = 1'b1;
                  tx_shift_n = hold_data;
                  tx_div_n   = act_div;
                  tx_state_n = TX_START;
               end else tx_state_n = TX_IDLE;
            end else tx_cnt_n = tx_cnt + CNT_W'(1);
         end
      endcase
   end

   assign tx_line = (tx_state == TX_START) ? 1'b0 :
                    (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bits  <= rx_bits_n;
         rx_shift <= rx_shift_n;
      end
   end

   assign rx_last = (rx_cnt == act_div - CNT_W'(1));
   assign rx_half = (rx_cnt == (act_div >> 1) - CNT_W'(1));

   // RX: mid-bit sampling; a port switch abandons any frame in progress
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bits_n  = rx_bits;
      rx_shift_n = rx_shift;
      rx_push    = 1'b0;
      set_fe     = 1'b0;
      set_ov     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_in) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            if (rx_half) begin
               rx_cnt_n   = '0;
               rx_bits_n  = '0;
               rx_state_n = rx_in ? RX_IDLE : RX_DATA;
            end else rx_cnt_n = rx_cnt + CNT_W'(1);
         end
         RX_DATA: begin
            if (rx_last) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_in, rx_shift[7:1]};
               rx_bits_n  = rx_bits + 3'd1;
               if (rx_bits == 3'd7) rx_state_n = RX_STOP;
            end else rx_cnt_n = rx_cnt + CNT_W'(1);
         end
         default: begin
            if (rx_last) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               if (!rx_in) set_fe = 1'b1;
               else if (fifo_full && !pop) set_ov = 1'b1;
               else rx_push = 1'b1;
            end else rx_cnt_n = rx_cnt + CNT_W'(1);
         end
      endcase
      if (port_chg) begin
         rx_state_n = RX_IDLE;
         rx_cnt_n   = '0;
         rx_push    = 1'b0;
         set_fe     = 1'b0;
         set_ov     = 1'b0;
      end
   end

   vicmidi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_push),
      .pop   (pop),
      .wdata (rx_shift),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign irq_int = (ctrl[CT_RX_IE] && rx_avail) || (ctrl[CT_TX_IE] && tx_ready) ||
                    overrun || framing_err;

   always_comb begin
      rdata = '0;
      case (bus.address)
         ADDR_DATA:   rdata = fifo_empty ? 8'h00 : fifo_rdata;
         ADDR_STATUS: begin
            rdata[ST_RX_AVAIL] = rx_avail;
            rdata[ST_TX_READY] = tx_ready;
            rdata[ST_OVERRUN]  = overrun;
            rdata[ST_FRAMING]  = framing_err;
            rdata[ST_IRQ]      = irq_int;
         end
         ADDR_CTRL:   rdata = {4'b0000, ctrl};
         ADDR_COUNT:  rdata = 8'(fifo_count);
         default:     rdata = '0;
      endcase
   end

   assign bus.data_out = rdata;
   assign bus.irq      = irq_int;
   assign rs232_txd    = port_sel ? tx_line : 1'b1;
   assign midi_txd     = thru ? midi_sync[1] : (port_sel ? 1'b1 : tx_line);

endmodule

// File: tb/tb_vicmidi_uart.sv
// Scoreboard bench for vicmidi_uart: register reads and serial TX frames are
// queued as expectations and checked by independent monitors.
module tb_vicmidi_uart;
   import vicmidi_pkg::*;

   logic clock = 1'b0;
   logic reset;
   logic midi_rxd, rs232_rxd, midi_txd, rs232_txd;
   always #5 clock = ~clock;

   vicmidi_uart_if bus();

   vicmidi_uart #(.DIV_MIDI(32), .DIV_RS232(106), .FIFO_DEPTH(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .midi_rxd  (midi_rxd),
      .rs232_rxd (rs232_rxd),
      .midi_txd  (midi_txd),
      .rs232_txd (rs232_txd)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] rd_exp_q[$];
   string      rd_nm_q[$];
   logic [7:0] txq_midi[$];
   logic [7:0] txq_rs[$];
   logic       mon_midi_en = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(posedge clock); #1;
      bus.cs = 1'b1; bus.r_w = 1'b0; bus.address = a; bus.data_in = d;
      @(posedge clock); #1;
      bus.cs = 1'b0; bus.r_w = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
      @(posedge clock); #1;
      rd_exp_q.push_back(exp);
      rd_nm_q.push_back(nm);
      bus.cs = 1'b1; bus.r_w = 1'b1; bus.address = a;
      @(posedge clock); #1;
      bus.cs = 1'b0;
   endtask

   task automatic set_rx(input int sel, input logic v);
      if (sel != 0) rs232_rxd = v;
      else midi_rxd = v;
   endtask

   task automatic send_rx(input int sel, input logic [7:0] b, input logic stopb, input int div);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         set_rx(sel, fr[i]);
         repeat (div - 1) @(posedge clock);
      end
      @(posedge clock); #1;
      set_rx(sel, 1'b1);
   endtask

   task automatic wait_txq(input int sel, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (((sel != 0) ? txq_rs.size() : txq_midi.size()) == 0) break;
         @(posedge clock);
      end
      chk((sel != 0) ? "tx_rs_done" : "tx_midi_done",
          (sel != 0) ? txq_rs.size() : txq_midi.size(), 0);
   endtask

   // Register read monitor: data_out is combinational, sampled mid-cycle
   always @(negedge clock) begin
      logic [7:0] e;
      string      nm;
      if (bus.cs === 1'b1 && bus.r_w === 1'b1) begin
         if (rd_exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_read: got 0x%0h, want none", bus.data_out);
         end else begin
            e  = rd_exp_q.pop_front();
            nm = rd_nm_q.pop_front();
            chk(nm, bus.data_out, e);
         end
      end
   end

   // Serial frame monitor: samples mid-bit and checks {stop, data, start}
   task automatic tx_mon(input int sel, input int div);
      logic [9:0] fr;
      logic [7:0] e;
      forever begin
         @(negedge clock);
         if (((sel != 0) ? rs232_txd : midi_txd) === 1'b0 && (sel != 0 || mon_midi_en)) begin
            repeat (div / 2 - 1) @(negedge clock);
            fr[0] = (sel != 0) ? rs232_txd : midi_txd;
            for (int i = 1; i < 10; i++) begin
               repeat (div) @(negedge clock);
               fr[i] = (sel != 0) ? rs232_txd : midi_txd;
            end
            if (((sel != 0) ? txq_rs.size() : txq_midi.size()) == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_frame line%0d: got 0x%0h, want none", sel, fr);
            end else begin
               e = (sel != 0) ? txq_rs.pop_front() : txq_midi.pop_front();
               chk((sel != 0) ? "rs232_frame" : "midi_frame", fr, {1'b1, e, 1'b0});
            end
         end
      end
   endtask

   initial tx_mon(0, 32);
   initial tx_mon(1, 106);

   initial begin
      repeat (60000) @(posedge clock);
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lows;
      logic [15:0] pat;
      reset = 1'b1; midi_rxd = 1'b1; rs232_rxd = 1'b1;
      bus.cs = 1'b0; bus.r_w = 1'b1; bus.address = '0; bus.data_in = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clock);
      chk("rst_midi_txd", midi_txd, 1);
      chk("rst_rs232_txd", rs232_txd, 1);
      chk("rst_irq", bus.irq, 0);
      rd(ADDR_STATUS, 8'h02, "rst_status");
      rd(ADDR_CTRL,   8'h00, "rst_ctrl");
      rd(ADDR_COUNT,  8'h00, "rst_count");
      rd(ADDR_DATA,   8'h00, "empty_data");
      rd(3'd5,        8'h00, "unused_reg");

      // MIDI TX of 0xA5; start bit one cycle after the write
      txq_midi.push_back(8'hA5);
      wr(ADDR_DATA, 8'hA5);
      @(negedge clock); chk("tx_pre_start", midi_txd, 1);
      @(negedge clock); chk("tx_start_bit", midi_txd, 0);
      lows = 0;
      for (int i = 0; i < 330; i++) begin
         @(negedge clock);
         if (rs232_txd !== 1'b1) lows++;
      end
      chk("rs232_idle_during_midi", lows, 0);
      wait_txq(0, 100);

      // MIDI RX of 0x3C, with rx interrupt
      send_rx(0, 8'h3C, 1'b1, 32);
      repeat (5) @(posedge clock);
      rd(ADDR_COUNT,  8'h01, "rx1_count");
      rd(ADDR_STATUS, 8'h03, "rx1_status");
      wr(ADDR_CTRL, 8'h02);
      rd(ADDR_STATUS, 8'h83, "rx1_status_ie");
      @(negedge clock); chk("rx1_irq_pin", bus.irq, 1);
      rd(ADDR_DATA,   8'h3C, "rx1_data");
      rd(ADDR_COUNT,  8'h00, "rx1_count_after");
      rd(ADDR_STATUS, 8'h02, "rx1_status_after");
      wr(ADDR_CTRL, 8'h00);

      // 17 bytes without reads: FIFO fills, last byte overruns
      for (int i = 0; i < 17; i++) send_rx(0, 8'(i * 17 + 5), 1'b1, 32);
      repeat (5) @(posedge clock);
      rd(ADDR_COUNT,  8'h10, "ovr_count");
      rd(ADDR_STATUS, 8'h87, "ovr_status");
      for (int i = 0; i < 16; i++) rd(ADDR_DATA, 8'(i * 17 + 5), "ovr_data");
      wr(ADDR_STATUS, 8'h04);
      rd(ADDR_STATUS, 8'h02, "ovr_cleared");
      rd(ADDR_COUNT,  8'h00, "ovr_drained");

      // Framing error, then a short glitch that must not start a frame
      send_rx(0, 8'h81, 1'b0, 32);
      repeat (5) @(posedge clock);
      rd(ADDR_STATUS, 8'h8A, "fe_status");
      rd(ADDR_COUNT,  8'h00, "fe_count");
      wr(ADDR_STATUS, 8'h08);
      rd(ADDR_STATUS, 8'h02, "fe_cleared");
      @(posedge clock); #1 midi_rxd = 1'b0;
      repeat (10) @(posedge clock);
      #1 midi_rxd = 1'b1;
      repeat (400) @(posedge clock);
      rd(ADDR_STATUS, 8'h02, "glitch_status");
      rd(ADDR_COUNT,  8'h00, "glitch_count");

      // RS-232 with THRU: streamed frames, a dropped third write, THRU latency
      mon_midi_en = 1'b0;
      wr(ADDR_CTRL, 8'h09);
      rd(ADDR_CTRL, 8'h09, "ctrl_rs_thru");
      txq_rs.push_back(8'h55);
      wr(ADDR_DATA, 8'h55);
      txq_rs.push_back(8'hC3);
      wr(ADDR_DATA, 8'hC3);
      wr(ADDR_DATA, 8'h77);
      rd(ADDR_STATUS, 8'h00, "tx_busy_status");
      pat = 16'b1011_0010_1100_1101;
      for (int k = 0; k < 16; k++) begin
         @(posedge clock); #1 midi_rxd = pat[k];
         @(negedge clock);
         if (k >= 2) chk("thru_delay2", midi_txd, pat[k - 2]);
      end
      @(posedge clock); #1 midi_rxd = 1'b1;
      wait_txq(1, 3000);
      repeat (60) @(posedge clock);

      // Reset during data bit 4 of a MIDI frame
      wr(ADDR_CTRL, 8'h04);
      @(negedge clock); chk("tx_ie_irq", bus.irq, 1);
      wr(ADDR_DATA, 8'h0F);
      repeat (178) @(negedge clock);
      chk("tx_bit4_low", midi_txd, 0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("midrst_midi_txd", midi_txd, 1);
      chk("midrst_rs232_txd", rs232_txd, 1);
      chk("midrst_irq", bus.irq, 0);
      reset = 1'b0;
      rd(ADDR_CTRL,   8'h00, "midrst_ctrl");
      rd(ADDR_STATUS, 8'h02, "midrst_status");
      repeat (5) @(posedge clock);

      chk("reads_pending", rd_exp_q.size(), 0);
      chk("midi_frames_pending", txq_midi.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
